// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with round-robin or forced-select
// arbitration, packet locking and one registered output stage.
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     in_valid,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [N_CH-1:0]     in_last,
    output logic [N_CH-1:0]     in_ready,
    input  logic                sel_en,
    input  logic [SEL_W-1:0]    sel,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_last,
    input  logic                out_ready
);
    typedef enum logic {ARB, LOCK} state_t;
    state_t           state;
    logic [SEL_W-1:0] ptr, lock_ch, gnt, idx;
    logic             gnt_v, accept;
    // Round-robin scans downwards so the channel nearest ptr+1 is assigned last and wins.
    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        idx   = '0;
        if (state == LOCK) begin
            gnt   = lock_ch;
            gnt_v = in_valid[lock_ch];
        end else if (sel_en) begin
            gnt   = sel;
            gnt_v = (int'(sel) < N_CH) && in_valid[sel];
        end else begin
            for (int i = N_CH; i >= 1; i--) begin
                idx = SEL_W'((int'(ptr) + i) % N_CH);
                if (in_valid[idx]) begin
                    gnt   = idx;
                    gnt_v = 1'b1;
                end
            end
        end
        accept        = gnt_v && rst_n && (!out_valid || out_ready);
        in_ready      = '0;
        in_ready[gnt] = accept;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            ptr       <= SEL_W'(N_CH - 1);
            lock_ch   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt)*W +: W];
            out_ch    <= gnt;
            out_last  <= in_last[gnt];
            state     <= in_last[gnt] ? ARB : LOCK;
            if (in_last[gnt]) ptr <= gnt;
            else lock_ch <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
